// File: rtl/opm_reg_file_v2.sv
// Host-side register file for the OPM core: bus decode, byte register array,
// write-busy timer, timer overflow flags with IRQ, and optional read-back.
module opm_reg_file_v2 #(
  parameter int         NUM_REGS        = 256,
  parameter int         BUSY_CYCLES     = 64,
  parameter logic [7:0] TIMER_CTRL_ADDR = 8'h14,
  parameter logic [7:0] CT_ADDR         = 8'h1B,
  parameter bit         READBACK        = 1'b0
) (
  input  logic                  phiM,
  input  logic                  IC,
  input  logic [7:0]            Din,
  input  logic                  CS_b,
  input  logic                  WR_b,
  input  logic                  RD_b,
  input  logic                  A0,
  input  logic                  TM_1,
  input  logic                  TM_2,
  output logic [7:0]            Dout,
  output logic                  Dout_en,
  output logic                  IRQ_b,
  output logic                  CT_1,
  output logic                  CT_2,
  output logic                  TA_LOAD,
  output logic                  TB_LOAD,
  output logic                  busy,
  output logic                  wr_stb,
  output logic [7:0]            wr_addr,
  output logic [7:0]            wr_data,
  output logic [NUM_REGS*8-1:0] regs_flat
);

  localparam int ADDR_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int CNT_W  = $clog2(BUSY_CYCLES + 1);
  localparam logic [8:0]        REG_LIMIT = 9'(NUM_REGS);
  localparam logic [CNT_W-1:0]  BUSY_LOAD = CNT_W'(BUSY_CYCLES);
  localparam bit CTRL_MAPPED = int'(TIMER_CTRL_ADDR) < NUM_REGS;
  localparam bit CT_MAPPED   = int'(CT_ADDR) < NUM_REGS;
  localparam logic [ADDR_W-1:0] CTRL_IDX = CTRL_MAPPED ? ADDR_W'(int'(TIMER_CTRL_ADDR)) : '0;
  localparam logic [ADDR_W-1:0] CT_IDX   = CT_MAPPED ? ADDR_W'(int'(CT_ADDR)) : '0;

  logic [7:0]       r_regs [NUM_REGS];
  logic [7:0]       r_addr;
  logic             r_wrQ;
  logic [CNT_W-1:0] r_busyCnt;
  logic             r_flagA;
  logic             r_flagB;

  logic              w_wrAct;
  logic              w_wrEvt;
  logic              w_rdAct;
  logic              w_busy;
  logic              w_addrMapped;
  logic              w_dataAcc;
  logic              w_ctrlWr;
  logic [ADDR_W-1:0] w_idx;
  logic [7:0]        w_curReg;
  logic [7:0]        w_ctrlReg;
  logic [7:0]        w_ctReg;
  logic [7:0]        w_status;
  logic [7:0]        w_rdData;
  logic              w_nextFlagA;
  logic              w_nextFlagB;

  assign w_wrAct      = ~CS_b & ~WR_b;
  assign w_rdAct      = ~CS_b & ~RD_b;
  assign w_wrEvt      = w_wrAct & ~r_wrQ;
  assign w_busy       = (r_busyCnt != '0);
  assign busy         = w_busy;
  assign w_addrMapped = ({1'b0, r_addr} < REG_LIMIT);
  assign w_idx        = r_addr[ADDR_W-1:0];
  assign w_dataAcc    = w_wrEvt & A0 & ~w_busy & w_addrMapped;
  assign w_ctrlWr     = w_dataAcc & (r_addr == TIMER_CTRL_ADDR);

  assign w_curReg  = w_addrMapped ? r_regs[w_idx] : 8'h00;
  assign w_ctrlReg = CTRL_MAPPED ? r_regs[CTRL_IDX] : 8'h00;
  assign w_ctReg   = CT_MAPPED ? r_regs[CT_IDX] : 8'h00;

  // Set beats clear so an overflow landing on the clearing write is not lost.
  assign w_nextFlagA = (TM_1 & w_ctrlReg[2]) | (r_flagA & ~(w_ctrlWr & Din[4]));
  assign w_nextFlagB = (TM_2 & w_ctrlReg[3]) | (r_flagB & ~(w_ctrlWr & Din[5]));

  assign w_status = {w_busy, 5'b00000, r_flagB, r_flagA};
  assign w_rdData = (READBACK && A0) ? w_curReg : w_status;

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign regs_flat[8*g +: 8] = r_regs[g];
  end

  always_ff @(posedge phiM or posedge IC) begin
    if (IC) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= 8'h00;
      r_addr <= 8'h00;
      r_wrQ  <= 1'b0;
    end else begin
      r_wrQ <= w_wrAct;
      if (w_wrEvt && !A0) r_addr <= Din;
      if (w_dataAcc) r_regs[w_idx] <= Din;
    end
  end

  // Busy is derived from the counter, so a load gives exactly BUSY_CYCLES high cycles.
  always_ff @(posedge phiM or posedge IC) begin
    if (IC) begin
      r_busyCnt <= '0;
    end else if (w_dataAcc) begin
      r_busyCnt <= BUSY_LOAD;
    end else if (w_busy) begin
      r_busyCnt <= r_busyCnt - 1'b1;
    end
  end

  always_ff @(posedge phiM or posedge IC) begin
    if (IC) begin
      wr_stb  <= 1'b0;
      wr_addr <= 8'h00;
      wr_data <= 8'h00;
    end else begin
      wr_stb <= w_dataAcc;
      if (w_dataAcc) begin
        wr_addr <= r_addr;
        wr_data <= Din;
      end
    end
  end

  always_ff @(posedge phiM or posedge IC) begin
    if (IC) begin
      r_flagA <= 1'b0;
      r_flagB <= 1'b0;
      IRQ_b   <= 1'b1;
      CT_1    <= 1'b0;
      CT_2    <= 1'b0;
      TA_LOAD <= 1'b0;
      TB_LOAD <= 1'b0;
    end else begin
      r_flagA <= w_nextFlagA;
      r_flagB <= w_nextFlagB;
      IRQ_b   <= ~(r_flagA | r_flagB);
      CT_1    <= w_ctReg[7];
      CT_2    <= w_ctReg[6];
      TA_LOAD <= w_ctrlReg[0];
      TB_LOAD <= w_ctrlReg[1];
    end
  end

  // Read data is captured from pre-edge state, so a concurrent write is not visible.
  always_ff @(posedge phiM or posedge IC) begin
    if (IC) begin
      Dout    <= 8'h00;
      Dout_en <= 1'b0;
    end else begin
      Dout_en <= w_rdAct;
      if (w_rdAct) Dout <= w_rdData;
    end
  end

endmodule

// File: tb/tb_opm_reg_file_v2.sv
// Self-checking bench: two register-file instances (full map with read-back,
// and a 32-register map) share one host bus and are compared to a cycle model.
module tb_opm_reg_file_v2;

  logic       phiM = 1'b0;
  logic       IC   = 1'b1;
  logic [7:0] Din  = 8'h00;
  logic       CS_b = 1'b1;
  logic       WR_b = 1'b1;
  logic       RD_b = 1'b1;
  logic       A0   = 1'b0;
  logic       TM_1 = 1'b0;
  logic       TM_2 = 1'b0;

  logic [7:0]    dout0, dout1, wa0, wa1, wd0, wd1;
  logic          den0, den1, irq0, irq1, ct10, ct11, ct20, ct21;
  logic          ta0, ta1, tb0, tb1, busy0, busy1, stb0, stb1;
  logic [2047:0] flat0;
  logic [255:0]  flat1;

  int  assertCount = 0;
  int  failCount   = 0;
  bit  checkEn     = 1'b0;

  opm_reg_file_v2 #(.NUM_REGS(256), .READBACK(1'b1)) dut0 (
    .phiM(phiM), .IC(IC), .Din(Din), .CS_b(CS_b), .WR_b(WR_b), .RD_b(RD_b),
    .A0(A0), .TM_1(TM_1), .TM_2(TM_2), .Dout(dout0), .Dout_en(den0),
    .IRQ_b(irq0), .CT_1(ct10), .CT_2(ct20), .TA_LOAD(ta0), .TB_LOAD(tb0),
    .busy(busy0), .wr_stb(stb0), .wr_addr(wa0), .wr_data(wd0), .regs_flat(flat0)
  );

  opm_reg_file_v2 #(.NUM_REGS(32), .READBACK(1'b0)) dut1 (
    .phiM(phiM), .IC(IC), .Din(Din), .CS_b(CS_b), .WR_b(WR_b), .RD_b(RD_b),
    .A0(A0), .TM_1(TM_1), .TM_2(TM_2), .Dout(dout1), .Dout_en(den1),
    .IRQ_b(irq1), .CT_1(ct11), .CT_2(ct21), .TA_LOAD(ta1), .TB_LOAD(tb1),
    .busy(busy1), .wr_stb(stb1), .wr_addr(wa1), .wr_data(wd1), .regs_flat(flat1)
  );

  always #5 phiM = ~phiM;

  function automatic int nrOf(input int k);
    return (k == 0) ? 256 : 32;
  endfunction

  function automatic bit rbOf(input int k);
    return (k == 0);
  endfunction

  // Cycle model: per edge, apply the bus/timer rules directly to arrays and counters.
  logic [7:0] mReg [2][256];
  logic [7:0] mAddr [2];
  int         busyLeft [2];
  logic       mFa [2], mFb [2];
  logic [7:0] eDout [2], eWa [2], eWd [2];
  logic       eDen [2], eIrq [2], eCt1 [2], eCt2 [2], eTa [2], eTb [2], eStb [2];
  logic       prevWr;
  logic       mWrAct, mEvt, mRdAct, mBusyNow, mClrA, mClrB;
  logic [7:0] mStatus, mCtrl, mCt;

  always @(posedge phiM or posedge IC) begin
    if (IC) begin
      prevWr = 1'b0;
      for (int k = 0; k < 2; k++) begin
        for (int i = 0; i < 256; i++) mReg[k][i] = 8'h00;
        mAddr[k] = 8'h00; busyLeft[k] = 0; mFa[k] = 1'b0; mFb[k] = 1'b0;
        eDout[k] = 8'h00; eDen[k] = 1'b0; eIrq[k] = 1'b1; eCt1[k] = 1'b0;
        eCt2[k] = 1'b0; eTa[k] = 1'b0; eTb[k] = 1'b0; eStb[k] = 1'b0;
        eWa[k] = 8'h00; eWd[k] = 8'h00;
      end
    end else begin
      mWrAct = !CS_b && !WR_b;
      mRdAct = !CS_b && !RD_b;
      mEvt   = mWrAct && !prevWr;
      for (int k = 0; k < 2; k++) begin
        mBusyNow = busyLeft[k] > 0;
        mStatus  = {mBusyNow, 5'b00000, mFb[k], mFa[k]};
        if (mRdAct) begin
          if (rbOf(k) && A0)
            eDout[k] = (int'(mAddr[k]) < nrOf(k)) ? mReg[k][mAddr[k]] : 8'h00;
          else
            eDout[k] = mStatus;
        end
        eDen[k] = mRdAct;
        eIrq[k] = !(mFa[k] || mFb[k]);
        mCtrl   = mReg[k][8'h14];
        mCt     = mReg[k][8'h1B];
        eCt1[k] = mCt[7];
        eCt2[k] = mCt[6];
        eTa[k]  = mCtrl[0];
        eTb[k]  = mCtrl[1];
        mClrA = 1'b0; mClrB = 1'b0; eStb[k] = 1'b0;
        if (busyLeft[k] > 0) busyLeft[k] = busyLeft[k] - 1;
        if (mEvt) begin
          if (!A0) begin
            mAddr[k] = Din;
          end else if (!mBusyNow && int'(mAddr[k]) < nrOf(k)) begin
            mReg[k][mAddr[k]] = Din;
            eStb[k] = 1'b1; eWa[k] = mAddr[k]; eWd[k] = Din;
            busyLeft[k] = 64;
            if (mAddr[k] == 8'h14) begin
              mClrA = Din[4]; mClrB = Din[5];
            end
          end
        end
        mFa[k] = (TM_1 && mCtrl[2]) || (mFa[k] && !mClrA);
        mFb[k] = (TM_2 && mCtrl[3]) || (mFb[k] && !mClrB);
      end
      prevWr = mWrAct;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    assertCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compareDut(input int k, input logic [7:0] dout, input logic den,
                            input logic irq, input logic ct1, input logic ct2,
                            input logic ta, input logic tb, input logic bsy,
                            input logic stb, input logic [7:0] wa, input logic [7:0] wd,
                            input logic [2047:0] flat);
    logic flatOk;
    checkOutput($sformatf("dut%0d.Dout", k), 32'(dout), 32'(eDout[k]));
    checkOutput($sformatf("dut%0d.Dout_en", k), 32'(den), 32'(eDen[k]));
    checkOutput($sformatf("dut%0d.IRQ_b", k), 32'(irq), 32'(eIrq[k]));
    checkOutput($sformatf("dut%0d.CT", k), 32'({ct1, ct2}), 32'({eCt1[k], eCt2[k]}));
    checkOutput($sformatf("dut%0d.LOAD", k), 32'({ta, tb}), 32'({eTa[k], eTb[k]}));
    checkOutput($sformatf("dut%0d.busy", k), 32'(bsy), 32'(busyLeft[k] > 0));
    checkOutput($sformatf("dut%0d.wr_stb", k), 32'(stb), 32'(eStb[k]));
    if (eStb[k]) checkOutput($sformatf("dut%0d.wr_addr_data", k), 32'({wa, wd}), 32'({eWa[k], eWd[k]}));
    flatOk = 1'b1;
    for (int i = 0; i < nrOf(k); i++)
      if (flat[8*i +: 8] !== mReg[k][i]) flatOk = 1'b0;
    checkOutput($sformatf("dut%0d.regs_flat", k), 32'(flatOk), 32'd1);
  endtask

  always @(negedge phiM) begin
    if (checkEn && !IC) begin
      compareDut(0, dout0, den0, irq0, ct10, ct20, ta0, tb0, busy0, stb0, wa0, wd0, flat0);
      compareDut(1, dout1, den1, irq1, ct11, ct21, ta1, tb1, busy1, stb1, wa1, wd1, {1792'b0, flat1});
    end
  end

  int stbCnt0 = 0, stbCnt1 = 0;
  int busyRun0 = 0, busyRun1 = 0, lastRun0 = 0, lastRun1 = 0;

  always @(posedge phiM) begin
    #1;
    if (stb0) stbCnt0++;
    if (stb1) stbCnt1++;
    if (busy0) busyRun0++;
    else if (busyRun0 != 0) begin lastRun0 = busyRun0; busyRun0 = 0; end
    if (busy1) busyRun1++;
    else if (busyRun1 != 0) begin lastRun1 = busyRun1; busyRun1 = 0; end
  end

  task automatic applyStimulus(input logic cs, input logic wr, input logic rd,
                               input logic a0, input logic [7:0] din);
    CS_b = cs; WR_b = wr; RD_b = rd; A0 = a0; Din = din;
  endtask

  task automatic busWrite(input logic a0, input logic [7:0] din);
    @(negedge phiM);
    applyStimulus(1'b0, 1'b0, 1'b1, a0, din);
    @(negedge phiM);
    applyStimulus(1'b1, 1'b1, 1'b1, a0, din);
  endtask

  task automatic busRead(input logic a0, input int n);
    @(negedge phiM);
    applyStimulus(1'b0, 1'b1, 1'b0, a0, Din);
    repeat (n) @(negedge phiM);
    applyStimulus(1'b1, 1'b1, 1'b1, a0, Din);
  endtask

  task automatic waitBusyClear();
    for (int i = 0; i < 300; i++) begin
      @(negedge phiM);
      if (!busy0 && !busy1) break;
    end
    checkOutput("busy_wait", 32'({busy0, busy1}), 32'd0);
  endtask

  int s0, s1;
  logic [255:0] saved1;

  initial begin
    repeat (3) @(negedge phiM);
    IC = 1'b0;
    checkEn = 1'b1;
    @(negedge phiM);
    checkOutput("reset_irq", 32'({irq0, irq1}), 32'b11);
    checkOutput("reset_busy_den", 32'({busy0, den0, busy1, den1}), 32'd0);
    checkOutput("reset_flat", 32'(flat0 == '0), 32'd1);

    // CT register write, busy length, and a dropped write during busy
    busWrite(1'b0, 8'h1B);
    busWrite(1'b1, 8'hC0);
    checkOutput("wr_stb_pulse", 32'({stb0, wa0, wd0}), 32'h11BC0);
    @(negedge phiM);
    checkOutput("ct_after_write", 32'({ct10, ct20}), 32'b11);
    repeat (7) @(negedge phiM);
    busWrite(1'b1, 8'h00);
    @(negedge phiM);
    checkOutput("ct_kept_when_busy", 32'({ct10, ct20}), 32'b11);
    checkOutput("stb_count_busy_drop", 32'(stbCnt0), 32'd1);
    waitBusyClear();
    checkOutput("busy_length", 32'(lastRun0), 32'd64);

    // Timer flags, IRQ and status reads
    busWrite(1'b0, 8'h14);
    busWrite(1'b1, 8'h04);
    waitBusyClear();
    @(negedge phiM); TM_1 = 1'b1;
    @(negedge phiM); TM_1 = 1'b0;
    @(negedge phiM);
    checkOutput("irq_after_tm1", 32'(irq0), 32'd0);
    busRead(1'b0, 1);
    checkOutput("status_flagA", 32'({den0, dout0}), 32'h101);
    @(negedge phiM);
    checkOutput("den_drop_hold", 32'({den0, dout0}), 32'h001);
    @(negedge phiM); TM_2 = 1'b1;
    @(negedge phiM); TM_2 = 1'b0;
    busRead(1'b0, 1);
    checkOutput("status_tm2_masked", 32'(dout0), 32'h01);
    busWrite(1'b0, 8'h14);
    busWrite(1'b1, 8'h14);
    @(negedge phiM);
    checkOutput("irq_after_clear", 32'(irq0), 32'd1);
    waitBusyClear();
    @(negedge phiM);
    TM_1 = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 8'h14);
    @(negedge phiM);
    TM_1 = 1'b0;
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 8'h14);
    @(negedge phiM);
    checkOutput("set_beats_clear", 32'(irq0), 32'd0);

    // Held write strobe gives a single event
    waitBusyClear();
    s0 = stbCnt0;
    @(negedge phiM);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 8'h33);
    repeat (5) @(negedge phiM);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 8'h33);
    @(negedge phiM);
    checkOutput("held_strobe_once", 32'(stbCnt0 - s0), 32'd1);
    checkOutput("load_bits", 32'({ta0, tb0}), 32'b11);

    // Read-back on the full map; address 0x20 is unmapped on the small map
    waitBusyClear();
    busWrite(1'b0, 8'h20);
    busWrite(1'b1, 8'h5A);
    busRead(1'b1, 3);
    checkOutput("readback", 32'({den0, dout0}), 32'h15A);
    checkOutput("small_status", 32'({busy1, dout1}), 32'h000);
    @(negedge phiM);
    checkOutput("readback_den_off", 32'(den0), 32'd0);

    // Unmapped write on the small map
    waitBusyClear();
    s1 = stbCnt1;
    saved1 = flat1;
    busWrite(1'b0, 8'h40);
    busWrite(1'b1, 8'hFF);
    @(negedge phiM);
    checkOutput("unmapped_no_stb", 32'(stbCnt1 - s1), 32'd0);
    checkOutput("unmapped_busy", 32'({busy0, busy1}), 32'b10);
    checkOutput("unmapped_flat", 32'(flat1 == saved1), 32'd1);

    // Asynchronous reset mid-busy and mid-read
    @(negedge phiM);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    @(negedge phiM);
    #2 IC = 1'b1;
    #1;
    checkOutput("async_busy", 32'({busy0, den0}), 32'd0);
    checkOutput("async_irq_ct", 32'({irq0, ct10, ct20, ta0}), 32'b1000);
    checkOutput("async_flat", 32'(flat0 == '0), 32'd1);
    @(negedge phiM);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 8'h00);
    IC = 1'b0;
    repeat (4) @(negedge phiM);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
